// File: rtl/codificador_instrucao.sv
// Program loader for the multicycle RV32I datapath: encodes one
// assembly-level instruction per handshake and writes it to imem.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   in_valid/in_ready    instruction handshake (accepted in IDLE only)
//   op, rd, rs1, rs2     operation code and register fields
//   imm                  I/S immediate, or beq byte offset bits [12:1]
//   finish               end-of-program strobe
//   imem_we/addr/wdata   one-cycle instruction-memory write port
//   count, full          words written, capacity reached
//   loaded, error        loading complete, illegal op seen (both sticky)
module codificador_instrucao #(
    parameter int ADDR_W    = 5,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       imm,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              loaded,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WRITE,
        S_FULL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } fields_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    state_t           state;
    fields_t          fld;
    logic [31:0]      enc_word;
    logic             enc_legal;
    logic [ADDR_W:0]  count_inc;

    assign in_ready  = (state == S_IDLE);
    assign count_inc = count + 1'b1;

    // Encoder works on the latched fields so the word is stable in ENC.
    // For beq, imm holds offset bits [12:1], hence imm[11] is bit 12 and
    // imm[10] is bit 11 of the branch offset.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        unique case (fld.op)
            3'd0: enc_word = {fld.imm, fld.rs1, 3'b010,
                              fld.rd, OPC_LOAD};
            3'd1: enc_word = {fld.imm[11:5], fld.rs2, fld.rs1,
                              3'b010, fld.imm[4:0], OPC_STORE};
            3'd2: enc_word = {7'b0100000, fld.rs2, fld.rs1,
                              3'b000, fld.rd, OPC_REG};
            3'd3: enc_word = {7'b0000000, fld.rs2, fld.rs1,
                              3'b100, fld.rd, OPC_REG};
            3'd4: enc_word = {fld.imm, fld.rs1, 3'b000,
                              fld.rd, OPC_IMM};
            3'd5: enc_word = {7'b0000000, fld.rs2, fld.rs1,
                              3'b101, fld.rd, OPC_REG};
            3'd6: enc_word = {fld.imm[11], fld.imm[9:4], fld.rs2,
                              fld.rs1, 3'b000, fld.imm[3:0],
                              fld.imm[10], OPC_BRANCH};
            default: enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fld        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            full       <= 1'b0;
            loaded     <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // A valid instruction wins over a same-cycle finish.
                    if (in_valid) begin
                        fld.op  <= op;
                        fld.rd  <= rd;
                        fld.rs1 <= rs1;
                        fld.rs2 <= rs2;
                        fld.imm <= imm;
                        state   <= S_ENC;
                    end else if (finish) begin
                        loaded <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_ENC: begin
                    if (enc_legal) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= count[ADDR_W-1:0];
                        imem_wdata <= enc_word;
                        state      <= S_WRITE;
                    end else begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    count <= count_inc;
                    if (count_inc == MAX_CNT) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FULL: begin
                    if (finish) begin
                        loaded <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codificador_instrucao.sv
// Self-checking bench for codificador_instrucao: directed scenarios
// plus randomized loading checked against an RV32I encoding model.
module tb_codificador_instrucao;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [11:0] imm = '0;
    logic        finish = 1'b0;

    logic        in_ready, imem_we, full, loaded, error;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [5:0]  count;

    logic        q4_in_ready, q4_imem_we, q4_full, q4_loaded, q4_error;
    logic [4:0]  q4_imem_addr;
    logic [31:0] q4_imem_wdata;
    logic [5:0]  q4_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int unsigned wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int unsigned a4[$];
    logic [31:0] d4[$];

    codificador_instrucao dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .finish(finish), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full),
        .loaded(loaded), .error(error)
    );

    codificador_instrucao #(.ADDR_W(5), .MAX_WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ready(q4_in_ready), .op(op), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .finish(finish),
        .imem_we(q4_imem_we), .imem_addr(q4_imem_addr),
        .imem_wdata(q4_imem_wdata), .count(q4_count),
        .full(q4_full), .loaded(q4_loaded), .error(q4_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(32'(imem_addr));
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
        if (q4_imem_we) begin
            a4.push_back(32'(q4_imem_addr));
            d4.push_back(q4_imem_wdata);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: RV32I field placement from the ISA manual, built with
    // shifts. For beq the 13-bit byte offset is rebuilt as imm*2.
    function automatic logic [31:0] model_enc(
        input int unsigned o, d, s1, s2, im);
        int unsigned off;
        int unsigned w;
        off = im * 2;
        case (o)
            0: w = (im << 20) | (s1 << 15) | (32'd2 << 12)
                   | (d << 7) | 32'h03;
            1: w = ((im >> 5) << 25) | (s2 << 20) | (s1 << 15)
                   | (32'd2 << 12) | ((im & 31) << 7) | 32'h23;
            2: w = (32'd32 << 25) | (s2 << 20) | (s1 << 15)
                   | (d << 7) | 32'h33;
            3: w = (s2 << 20) | (s1 << 15) | (32'd4 << 12)
                   | (d << 7) | 32'h33;
            4: w = (im << 20) | (s1 << 15) | (d << 7) | 32'h13;
            5: w = (s2 << 20) | (s1 << 15) | (32'd5 << 12)
                   | (d << 7) | 32'h33;
            6: w = (((off >> 12) & 1) << 31)
                   | (((off >> 5) & 63) << 25)
                   | (s2 << 20) | (s1 << 15)
                   | (((off >> 1) & 15) << 8)
                   | (((off >> 11) & 1) << 7) | 32'h63;
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic drive(input int unsigned o, d, s1, s2, im,
                         input logic v, input logic fin);
        in_valid = v;
        finish   = fin;
        op  = 3'(o);
        rd  = 5'(d);
        rs1 = 5'(s1);
        rs2 = 5'(s2);
        imm = 12'(im);
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete();
        a4.delete(); d4.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // Present one instruction when ready, then let ENC/WRITE complete.
    task automatic send(input int unsigned o, d, s1, s2, im,
                        input logic fin, output int tp);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: in_ready=%0b required 1",
                     in_ready);
            tp = -1;
            return;
        end
        drive(o, d, s1, s2, im, 1'b1, fin);
        tp = cyc;
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic v, input logic fin);
        @(negedge clk);
        drive(4, 7, 1, 0, 9, v, fin);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready: got %0b want 1", in_ready); end
        checks++;
        if (count !== 6'd0 || imem_we !== 1'b0) begin errors++;
            $display("FAIL rst_count_we: got %0d/%0b want 0/0",
                     count, imem_we); end
        checks++;
        if (imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin errors++;
            $display("FAIL rst_port: got %0d/%h want 0/0",
                     imem_addr, imem_wdata); end
        checks++;
        if ({full, loaded, error} !== 3'b000) begin errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {full, loaded, error}); end
    endtask

    task automatic test_addi();
        int tp;
        do_reset();
        send(4, 1, 0, 0, 5, 1'b0, tp);
        checks++;
        if (wa.size() != 1) begin errors++;
            $display("FAIL addi_nwr: got %0d want 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++;
            if (wa[0] != 0 || wd[0] !== 32'h00500093) begin errors++;
                $display("FAIL addi_word: got %0d/%h want 0/00500093",
                         wa[0], wd[0]); end
            checks++;
            if (wd[0] !== model_enc(4, 1, 0, 0, 5)) begin errors++;
                $display("FAIL addi_model: got %h want %h",
                         wd[0], model_enc(4, 1, 0, 0, 5)); end
            checks++;
            if (wc[0] != tp + 2) begin errors++;
                $display("FAIL addi_lat: got %0d want %0d",
                         wc[0], tp + 2); end
        end
        checks++;
        if (count !== 6'd1 || in_ready !== 1'b1) begin errors++;
            $display("FAIL addi_count: got %0d/%0b want 1/1",
                     count, in_ready); end
    endtask

    task automatic test_sequence();
        int unsigned so[6] = '{2, 3, 5, 0, 1, 6};
        int unsigned sd[6] = '{3, 5, 6, 4, 0, 0};
        int unsigned s1[6] = '{1, 3, 5, 0, 0, 1};
        int unsigned s2[6] = '{2, 1, 1, 0, 2, 2};
        int unsigned si[6] = '{0, 0, 0, 8, 8, 12'hFFC};
        logic [31:0] ex[6] = '{32'h402081B3, 32'h0011C2B3,
                               32'h0012D333, 32'h00802203,
                               32'h00202423, 32'hFE208CE3};
        int tp;
        do_reset();
        for (int i = 0; i < 6; i++)
            send(so[i], sd[i], s1[i], s2[i], si[i], 1'b0, tp);
        checks++;
        if (wa.size() != 6 || count !== 6'd6) begin errors++;
            $display("FAIL seq_n: got %0d/%0d want 6/6",
                     wa.size(), count); end
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] != i || wd[i] !== ex[i]) begin errors++;
                $display("FAIL seq_word%0d: got %0d/%h want %0d/%h",
                         i, wa[i], wd[i], i, ex[i]); end
            checks++;
            if (wd[i] !== model_enc(so[i], sd[i], s1[i], s2[i], si[i]))
            begin errors++;
                $display("FAIL seq_model%0d: got %h", i, wd[i]); end
        end
    endtask

    task automatic test_illegal();
        int tp;
        do_reset();
        send(4, 1, 0, 0, 5, 1'b0, tp);
        @(negedge clk);
        drive(7, 3, 3, 3, 3, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL ill_enc: got rdy=%0b err=%0b want 0/0",
                     in_ready, error); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || error !== 1'b1) begin errors++;
            $display("FAIL ill_after: got rdy=%0b err=%0b want 1/1",
                     in_ready, error); end
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 1 || count !== 6'd1) begin errors++;
            $display("FAIL ill_nowr: got %0d/%0d want 1/1",
                     wa.size(), count); end
        send(4, 2, 0, 0, 7, 1'b0, tp);
        checks++;
        if (wa.size() != 2 || wa[$] != 1 ||
            wd[$] !== model_enc(4, 2, 0, 0, 7)) begin errors++;
            $display("FAIL ill_next: got n=%0d addr=%0d want 2/1",
                     wa.size(), wa[$]); end
    endtask

    task automatic test_full();
        int tp;
        int unsigned fd[4], f1[4], fi[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fd[i] = $urandom_range(0, 31);
            f1[i] = $urandom_range(0, 31);
            fi[i] = $urandom_range(0, 4095);
            send(4, fd[i], f1[i], 0, fi[i], 1'b0, tp);
            if (i == 2) begin
                checks++;
                if (q4_full !== 1'b0 || q4_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_early: got %0b/%0b want 0/1",
                             q4_full, q4_in_ready); end
            end
        end
        checks++;
        if (q4_full !== 1'b1 || q4_in_ready !== 1'b0 ||
            q4_count !== 6'd4) begin errors++;
            $display("FAIL full_set: got f=%0b r=%0b c=%0d want 1/0/4",
                     q4_full, q4_in_ready, q4_count); end
        for (int i = 0; i < 4 && i < a4.size(); i++) begin
            checks++;
            if (a4[i] != i ||
                d4[i] !== model_enc(4, fd[i], f1[i], 0, fi[i])) begin
                errors++;
                $display("FAIL full_word%0d: got %0d/%h", i,
                         a4[i], d4[i]); end
        end
        poke(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (a4.size() != 4 || q4_count !== 6'd4) begin errors++;
            $display("FAIL full_ignore: got %0d/%0d want 4/4",
                     a4.size(), q4_count); end
        poke(1'b0, 1'b1);
        checks++;
        if (q4_loaded !== 1'b1 || q4_full !== 1'b1) begin errors++;
            $display("FAIL full_finish: got l=%0b f=%0b want 1/1",
                     q4_loaded, q4_full); end
    endtask

    task automatic test_rst_mid();
        int tp;
        do_reset();
        send(7, 0, 0, 0, 0, 1'b0, tp);
        @(negedge clk);
        drive(4, 1, 0, 0, 5, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || count !== 6'd0 || error !== 1'b0)
        begin errors++;
            $display("FAIL rstmid_state: got r=%0b c=%0d e=%0b want 1/0/0",
                     in_ready, count, error); end
        repeat (4) @(negedge clk);
        checks++;
        if (wa.size() != 0) begin errors++;
            $display("FAIL rstmid_nowr: got %0d writes want 0",
                     wa.size()); end
    endtask

    task automatic test_valid_finish();
        int tp;
        do_reset();
        send(4, 9, 2, 0, 33, 1'b1, tp);
        checks++;
        if (wa.size() != 1 || loaded !== 1'b0 || count !== 6'd1) begin
            errors++;
            $display("FAIL vf_both: got n=%0d l=%0b want 1/0",
                     wa.size(), loaded); end
        poke(1'b0, 1'b1);
        checks++;
        if (loaded !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL vf_done: got l=%0b r=%0b want 1/0",
                     loaded, in_ready); end
        poke(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 1 || count !== 6'd1 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL vf_ignore: got n=%0d c=%0d want 1/1",
                     wa.size(), count); end
    endtask

    task automatic test_random();
        int tp, guard;
        int unsigned n, o, d, s1, s2, im;
        do_reset();
        n = 0;
        guard = 0;
        while (n < 32 && guard < 200) begin
            guard++;
            o  = $urandom_range(0, 7);
            d  = $urandom_range(0, 31);
            s1 = $urandom_range(0, 31);
            s2 = $urandom_range(0, 31);
            im = $urandom_range(0, 4095);
            send(o, d, s1, s2, im, 1'b0, tp);
            if (o == 7) begin
                checks++;
                if (wa.size() != n || error !== 1'b1) begin errors++;
                    $display("FAIL rnd_ill: got n=%0d e=%0b want %0d/1",
                             wa.size(), error, n); end
            end else begin
                checks++;
                if (wa.size() != n + 1 || wa[$] != n ||
                    wd[$] !== model_enc(o, d, s1, s2, im) ||
                    wc[$] != tp + 2) begin errors++;
                    $display("FAIL rnd_wr op=%0d: got a=%0d d=%h want %0d/%h",
                             o, wa[$], wd[$], n,
                             model_enc(o, d, s1, s2, im)); end
                n++;
            end
            checks++;
            if (count !== 6'(n)) begin errors++;
                $display("FAIL rnd_count: got %0d want %0d", count, n); end
        end
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 6'd32)
        begin errors++;
            $display("FAIL rnd_full: got f=%0b r=%0b c=%0d want 1/0/32",
                     full, in_ready, count); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sequence();
        test_illegal();
        test_full();
        test_rst_mid();
        test_valid_finish();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
